// File: rtl/clock_pkg.sv
// Shared definitions for the BCD time-of-day engine: field layout, limits, alarm states.
package clock_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned FIELD_W = 2 * BCD_W;
  localparam int unsigned TIME_W  = 4 * FIELD_W;

  localparam int unsigned HH_LSB = 24;
  localparam int unsigned MM_LSB = 16;
  localparam int unsigned SS_LSB = 8;
  localparam int unsigned CS_LSB = 0;

  localparam int unsigned HH_MAX = 23;
  localparam int unsigned MM_MAX = 59;
  localparam int unsigned SS_MAX = 59;
  localparam int unsigned CS_MAX = 99;

  typedef enum logic {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } alarm_state_e;

  typedef enum logic [1:0] {
    FLD_CS = 2'd0,
    FLD_SS = 2'd1,
    FLD_MM = 2'd2,
    FLD_HH = 2'd3
  } field_e;

  typedef struct packed {
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] minute;
    logic [FIELD_W-1:0] second;
    logic [FIELD_W-1:0] centi;
  } time_word_t;

  // True when v is two valid BCD digits whose decimal value does not exceed max_val.
  function automatic logic bcd_in_range(input logic [FIELD_W-1:0] v, input int unsigned max_val);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = v[FIELD_W-1:BCD_W];
    units = v[BCD_W-1:0];
    return (units <= BCD_W'(9)) && (tens <= BCD_W'(9)) &&
           ((32'(tens) * 32'd10 + 32'(units)) <= 32'(max_val));
  endfunction

endpackage

// File: rtl/bcd_timekeeper_if.sv
// Host-side bundle of the timekeeper: field writes, alarm acknowledge, time/alarm/status outputs.
interface bcd_timekeeper_if;
  import clock_pkg::*;

  logic [FIELD_W-1:0] time_in;
  logic               set_hour;
  logic               set_minute;
  logic               set_second;
  logic               set_mil;
  logic               set_time;
  logic               set_alarm;
  logic               alarm_ack;
  logic [TIME_W-1:0]  time_out;
  logic [TIME_W-1:0]  alarm_out;
  logic               tick;
  logic               wr_err;
  logic               alarm_sound;

  modport master (
    output time_in, set_hour, set_minute, set_second, set_mil, set_time, set_alarm, alarm_ack,
    input  time_out, alarm_out, tick, wr_err, alarm_sound
  );

  modport slave (
    input  time_in, set_hour, set_minute, set_second, set_mil, set_time, set_alarm, alarm_ack,
    output time_out, alarm_out, tick, wr_err, alarm_sound
  );
endinterface

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter 00..MAX with clear > load > inc priority; carry_out flags the wrap.
module bcd_field_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 99
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               inc,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] q,
  output logic [FIELD_W-1:0] q_nxt_c,
  output logic               carry_out
);

  localparam logic [FIELD_W-1:0] MAX_BCD = FIELD_W'(((MAX / 10) << BCD_W) | (MAX % 10));

  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] units;

  assign tens      = q[FIELD_W-1:BCD_W];
  assign units     = q[BCD_W-1:0];
  assign carry_out = inc && (q == MAX_BCD);

  // Next value is exported so the parent can see the post-tick word before it lands.
  always_comb begin
    q_nxt_c = q;
    if (clear) begin
      q_nxt_c = '0;
    end else if (load) begin
      q_nxt_c = load_val;
    end else if (inc) begin
      if (q == MAX_BCD) begin
        q_nxt_c = '0;
      end else if (units == BCD_W'(9)) begin
        q_nxt_c = {tens + BCD_W'(1), BCD_W'(0)};
      end else begin
        q_nxt_c = {tens, units + BCD_W'(1)};
      end
    end
  end

  always_ff @(posedge clk) begin
    q <= q_nxt_c;
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// Time-of-day engine HH:MM:SS:hh in packed BCD with field writes and an alarm.
// ALARM_TONE_EN: when defined, alarm_sound is beep-gated while ringing instead of held high.
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned RING_SECS = 30,
  parameter int unsigned TONE_HZ   = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  bcd_timekeeper_if.slave  bus
);

  localparam int unsigned DIV        = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W      = $clog2(DIV);
  localparam int unsigned RING_TICKS = RING_SECS * TICK_HZ;
  localparam int unsigned RING_W     = $clog2(RING_TICKS + 1);
  localparam int unsigned TONE_TICKS = TICK_HZ / (2 * TONE_HZ);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (RING_SECS < 1 || RING_SECS > 255) begin : g_bad_ring
    $error("RING_SECS must be in 1..255");
  end
  if (TONE_TICKS < 1) begin : g_bad_tone
    $error("TICK_HZ/(2*TONE_HZ) must be at least 1");
  end

  logic [PRE_W-1:0]  presc_q;
  logic              tick_q;
  logic              err_q;
  logic [TIME_W-1:0] alarm_q;

  field_e            sel_c;
  int unsigned       field_max_c;
  logic              any_sel_c;
  logic              data_ok_c;
  logic              time_wr_c;
  logic              alarm_wr_c;
  logic              err_c;
  logic              adv_c;
  time_word_t        next_time_c;

  // Highest-priority selected field and its legal ceiling.
  always_comb begin
    sel_c = FLD_CS;
    if (bus.set_hour) begin
      sel_c = FLD_HH;
    end else if (bus.set_minute) begin
      sel_c = FLD_MM;
    end else if (bus.set_second) begin
      sel_c = FLD_SS;
    end
  end

  always_comb begin
    case (sel_c)
      FLD_HH:  field_max_c = HH_MAX;
      FLD_MM:  field_max_c = MM_MAX;
      FLD_SS:  field_max_c = SS_MAX;
      default: field_max_c = CS_MAX;
    endcase
  end

  assign any_sel_c  = bus.set_hour | bus.set_minute | bus.set_second | bus.set_mil;
  assign data_ok_c  = any_sel_c && bcd_in_range(bus.time_in, field_max_c);
  assign time_wr_c  = bus.set_time && data_ok_c;
  assign alarm_wr_c = !bus.set_time && bus.set_alarm && data_ok_c;
  assign err_c      = (bus.set_time || bus.set_alarm) && !data_ok_c;
  assign adv_c      = (presc_q == PRE_W'(DIV - 1)) && !time_wr_c;

  // A time write restarts the tick period and swallows a coincident terminal count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tick_q <= adv_c;
      err_q  <= err_c;
      if (time_wr_c || adv_c) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      alarm_q <= '0;
    end else if (alarm_wr_c) begin
      case (sel_c)
        FLD_HH:  alarm_q[HH_LSB +: FIELD_W] <= bus.time_in;
        FLD_MM:  alarm_q[MM_LSB +: FIELD_W] <= bus.time_in;
        FLD_SS:  alarm_q[SS_LSB +: FIELD_W] <= bus.time_in;
        default: alarm_q[CS_LSB +: FIELD_W] <= bus.time_in;
      endcase
    end
  end

  logic [FIELD_W-1:0] cs_q, ss_q, mm_q, hh_q;
  logic               cs_carry, ss_carry, mm_carry, hh_carry;

  bcd_field_counter #(.MAX(CS_MAX)) u_cs (
    .clk(CLOCK_50), .clear(reset), .inc(adv_c),
    .load(time_wr_c && sel_c == FLD_CS), .load_val(bus.time_in),
    .q(cs_q), .q_nxt_c(next_time_c.centi), .carry_out(cs_carry)
  );

  bcd_field_counter #(.MAX(SS_MAX)) u_ss (
    .clk(CLOCK_50), .clear(reset), .inc(cs_carry),
    .load(time_wr_c && sel_c == FLD_SS), .load_val(bus.time_in),
    .q(ss_q), .q_nxt_c(next_time_c.second), .carry_out(ss_carry)
  );

  bcd_field_counter #(.MAX(MM_MAX)) u_mm (
    .clk(CLOCK_50), .clear(reset), .inc(ss_carry),
    .load(time_wr_c && sel_c == FLD_MM), .load_val(bus.time_in),
    .q(mm_q), .q_nxt_c(next_time_c.minute), .carry_out(mm_carry)
  );

  bcd_field_counter #(.MAX(HH_MAX)) u_hh (
    .clk(CLOCK_50), .clear(reset), .inc(mm_carry),
    .load(time_wr_c && sel_c == FLD_HH), .load_val(bus.time_in),
    .q(hh_q), .q_nxt_c(next_time_c.hour), .carry_out(hh_carry)
  );

  // End-of-day carry must land on midnight.
  a_day_wrap: assert property (@(posedge CLOCK_50) disable iff (reset)
                               hh_carry |-> (next_time_c == '0));

  alarm_state_e      state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic              sound_q, sound_d;
`ifdef ALARM_TONE_EN
  localparam int unsigned TONE_W = $clog2(TONE_TICKS + 1);
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      sound_q    <= 1'b0;
`ifdef ALARM_TONE_EN
      tone_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      sound_q    <= sound_d;
`ifdef ALARM_TONE_EN
      tone_cnt_q <= tone_cnt_d;
`endif
    end
  end

  // Trigger only on a tick whose resulting time equals the current alarm word.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    sound_d    = sound_q;
`ifdef ALARM_TONE_EN
    tone_cnt_d = tone_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        sound_d = 1'b0;
        if (adv_c && (next_time_c == alarm_q) && !bus.alarm_ack) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
          sound_d    = 1'b1;
`ifdef ALARM_TONE_EN
          tone_cnt_d = '0;
`endif
        end
      end
      RINGING: begin
        if (bus.alarm_ack) begin
          state_d = IDLE;
          sound_d = 1'b0;
        end else if (adv_c) begin
          if (ring_cnt_q == RING_W'(RING_TICKS - 1)) begin
            state_d = IDLE;
            sound_d = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + RING_W'(1);
`ifdef ALARM_TONE_EN
            if (tone_cnt_q == TONE_W'(TONE_TICKS - 1)) begin
              tone_cnt_d = '0;
              sound_d    = !sound_q;
            end else begin
              tone_cnt_d = tone_cnt_q + TONE_W'(1);
            end
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        sound_d = 1'b0;
      end
    endcase
  end

  assign bus.time_out[HH_LSB +: FIELD_W] = hh_q;
  assign bus.time_out[MM_LSB +: FIELD_W] = mm_q;
  assign bus.time_out[SS_LSB +: FIELD_W] = ss_q;
  assign bus.time_out[CS_LSB +: FIELD_W] = cs_q;
  assign bus.alarm_out   = alarm_q;
  assign bus.tick        = tick_q;
  assign bus.wr_err      = err_q;
  assign bus.alarm_sound = sound_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Randomized self-checking bench for bcd_timekeeper against a centisecond-count reference model.
module tb_bcd_timekeeper;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned TICK_HZ   = 100;
  localparam int unsigned RING_SECS = 2;
  localparam int unsigned TONE_HZ   = 4;
  localparam int DIV        = 10;
  localparam int RING_TICKS = 200;
  localparam int TONE_TICKS = 12;
  localparam int DAY        = 8640000;

  logic CLOCK_50 = 1'b0;
  logic reset;

  bcd_timekeeper_if bus ();

  bcd_timekeeper #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .RING_SECS(RING_SECS), .TONE_HZ(TONE_HZ)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int m_time, m_alarm, m_phase, m_rticks;
  bit m_ring, e_tick, e_err, e_sound;
  int n_vec, n_err, cyc;

  function automatic logic [7:0] bcd2(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] to_word(input int cs);
    return {bcd2(cs / 360000), bcd2((cs / 6000) % 60), bcd2((cs / 100) % 60), bcd2(cs % 100)};
  endfunction

  function automatic int put_field(input int cs, input int fld, input int val);
    int f[4];
    f[3] = cs / 360000; f[2] = (cs / 6000) % 60; f[1] = (cs / 100) % 60; f[0] = cs % 100;
    f[fld] = val;
    return ((f[3] * 60 + f[2]) * 60 + f[1]) * 100 + f[0];
  endfunction

  function automatic int field_lim(input int fld);
    return (fld == 3) ? 23 : (fld == 0) ? 99 : 59;
  endfunction

  function automatic logic [66:0] obs();
    return {bus.time_out, bus.alarm_out, bus.tick, bus.wr_err, bus.alarm_sound};
  endfunction

  function automatic logic [66:0] expv();
    return {to_word(m_time), to_word(m_alarm), e_tick, e_err, e_sound};
  endfunction

  // Advance the model on the current inputs, then clock the DUT.
  task automatic step();
    int fld, t, u, val, old_alarm;
    bit any, ok, twr, awr;
    if (reset) begin
      m_time = 0; m_alarm = 0; m_phase = 0; m_ring = 0; m_rticks = 0;
      e_tick = 0; e_err = 0; e_sound = 0;
    end else begin
      any = bus.set_hour | bus.set_minute | bus.set_second | bus.set_mil;
      fld = bus.set_hour ? 3 : bus.set_minute ? 2 : bus.set_second ? 1 : 0;
      t = int'(bus.time_in[7:4]);
      u = int'(bus.time_in[3:0]);
      val = t * 10 + u;
      ok = any && t <= 9 && u <= 9 && val <= field_lim(fld);
      e_err = (bus.set_time | bus.set_alarm) && !ok;
      twr = bus.set_time && ok;
      awr = !bus.set_time && bus.set_alarm && ok;
      old_alarm = m_alarm;
      e_tick = 0;
      if (twr) begin
        m_time = put_field(m_time, fld, val);
        m_phase = 0;
      end else begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_time = (m_time + 1) % DAY;
          e_tick = 1;
        end
      end
      if (awr) m_alarm = put_field(m_alarm, fld, val);
      if (!m_ring) begin
        if (e_tick && m_time == old_alarm && !bus.alarm_ack) begin
          m_ring = 1; m_rticks = 0;
        end
      end else if (bus.alarm_ack) begin
        m_ring = 0;
      end else if (e_tick) begin
        m_rticks++;
        if (m_rticks == RING_TICKS) m_ring = 0;
      end
`ifdef ALARM_TONE_EN
      e_sound = m_ring && (((m_rticks / TONE_TICKS) % 2) == 0);
`else
      e_sound = m_ring;
`endif
    end
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit st, input bit sa, input logic [3:0] sel, input logic [7:0] v);
    {bus.set_hour, bus.set_minute, bus.set_second, bus.set_mil} = sel;
    bus.set_time  = st;
    bus.set_alarm = sa;
    bus.time_in   = v;
  endtask

  task automatic do_reset();
    drive(0, 0, 4'b0, 8'h00);
    bus.alarm_ack = 0;
    reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 4'b0, 8'h00);
    bus.alarm_ack = 0;
    reset = 1; step(); step();
    n_vec++;
    if (obs() !== 67'd0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", obs());
    end
    reset = 0;
  endtask

  task automatic test_count();
    int last;
    last = -1;
    for (int i = 0; i < 100 * DIV; i++) begin
      step();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL count_cycle: got %h want %h", obs(), expv());
      end
      if (bus.tick === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (cyc - last !== DIV) begin
            n_err++; $display("FAIL tick_spacing: got %0d want %0d", cyc - last, DIV);
          end
        end
        last = cyc;
      end
    end
    n_vec++;
    if (bus.time_out !== 32'h00000100) begin
      n_err++; $display("FAIL count_100_ticks: got %h want 00000100", bus.time_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] vals [4];
    vals = '{8'h23, 8'h59, 8'h59, 8'h99};
    do_reset();
    for (int f = 0; f < 4; f++) begin
      drive(1, 0, 4'b1000 >> f, vals[f]);
      step();
    end
    drive(0, 0, 4'b0, 8'h00);
    n_vec++;
    if (bus.time_out !== 32'h23595999) begin
      n_err++; $display("FAIL wrap_preset: got %h want 23595999", bus.time_out);
    end
    for (int i = 0; i < DIV; i++) begin
      step();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL wrap_cycle: got %h want %h", obs(), expv());
      end
    end
    n_vec++;
    if (bus.time_out !== 32'h00000000 || $isunknown(obs())) begin
      n_err++; $display("FAIL wrap_midnight: got %h want 00000000", bus.time_out);
    end
  endtask

  task automatic test_bad_writes();
    logic [7:0] bv [10];
    logic [5:0] bc [10];
    bv = '{8'h60, 8'h1A, 8'h24, 8'h30, 8'h5F, 8'hA0, 8'h12, 8'h12, 8'h24, 8'h45};
    bc = '{6'b100100, 6'b100100, 6'b101000, 6'b101000, 6'b100010, 6'b100001,
           6'b100000, 6'b010000, 6'b011000, 6'b101100};
    do_reset();
    drive(1, 0, 4'b0100, 8'h37); step();
    for (int i = 0; i < 10; i++) begin
      drive(bc[i][5], bc[i][4], bc[i][3:0], bv[i]);
      step();
      drive(0, 0, 4'b0, 8'h00);
      n_vec++;
      if (bus.wr_err !== 1'b1 || obs() !== expv()) begin
        n_err++; $display("FAIL bad_write_%0d: got %h want %h", i, obs(), expv());
      end
      step();
      n_vec++;
      if (bus.wr_err !== 1'b0 || obs() !== expv()) begin
        n_err++; $display("FAIL bad_write_pulse_%0d: got %h want %h", i, obs(), expv());
      end
    end
    drive(1, 1, 4'b0010, 8'h42); step();
    drive(0, 0, 4'b0, 8'h00);
    n_vec++;
    if (obs() !== expv() || bus.alarm_out !== 32'h0) begin
      n_err++; $display("FAIL time_over_alarm: got %h want %h", obs(), expv());
    end
  endtask

  task automatic setup_alarm_105();
    do_reset();
    drive(0, 1, 4'b0010, 8'h01); step();
    drive(0, 1, 4'b0001, 8'h05); step();
    drive(1, 0, 4'b0001, 8'h00); step();
    drive(0, 0, 4'b0, 8'h00);
  endtask

  task automatic test_alarm_ack();
    int ticks, n;
    setup_alarm_105();
    ticks = 0; n = 0;
    while (ticks < 105 && n < 1300) begin
      step(); n++;
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL alarm_run: got %h want %h", obs(), expv());
      end
      if (bus.tick === 1'b1) ticks++;
    end
    n_vec++;
    if (ticks < 105 || bus.alarm_sound !== 1'b1 || bus.time_out !== 32'h00000105) begin
      n_err++; $display("FAIL alarm_rise: got sound=%b time=%h want 1 00000105",
                        bus.alarm_sound, bus.time_out);
    end
    step();
    bus.alarm_ack = 1; step(); bus.alarm_ack = 0;
    n_vec++;
    if (bus.alarm_sound !== 1'b0 || obs() !== expv()) begin
      n_err++; $display("FAIL alarm_ack: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_ring_timeout();
    int ticks, n;
    setup_alarm_105();
    ticks = 0; n = 0;
    while (ticks < 105 + RING_TICKS && n < 4000) begin
      step(); n++;
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL ring_run: got %h want %h", obs(), expv());
      end
      if (bus.tick === 1'b1) ticks++;
      if (ticks == 105 + RING_TICKS - 1 && bus.tick === 1'b1) begin
        n_vec++;
`ifdef ALARM_TONE_EN
        if (bus.alarm_sound !== 1'b1) begin
`else
        if (bus.alarm_sound !== 1'b1) begin
`endif
          n_err++; $display("FAIL ring_last_tick: got %b want 1", bus.alarm_sound);
        end
      end
    end
    n_vec++;
    if (ticks < 105 + RING_TICKS || bus.alarm_sound !== 1'b0) begin
      n_err++; $display("FAIL ring_timeout: got ticks=%0d sound=%b want %0d 0",
                        ticks, bus.alarm_sound, 105 + RING_TICKS);
    end
  endtask

  task automatic test_set_at_tc();
    int n, fld;
    logic [7:0] v;
    for (int rep = 0; rep < 4; rep++) begin
      do_reset();
      n = $urandom_range(0, 30);
      for (int i = 0; i < n; i++) step();
      n = 0;
      while (m_phase != DIV - 1 && n < 20) begin step(); n++; end
      fld = $urandom_range(0, 3);
      v = bcd2($urandom_range(0, field_lim(fld)));
      drive(1, 0, 4'b0001 << fld, v);
      step();
      drive(0, 0, 4'b0, 8'h00);
      n_vec++;
      if (bus.tick !== 1'b0 || obs() !== expv()) begin
        n_err++; $display("FAIL set_at_tc: got %h want %h", obs(), expv());
      end
      n = 0;
      do begin step(); n++; end while (bus.tick !== 1'b1 && n < 30);
      n_vec++;
      if (n !== DIV) begin
        n_err++; $display("FAIL set_at_tc_next_tick: got %0d want %0d", n, DIV);
      end
    end
  endtask

  task automatic test_reset_ringing();
    int n;
    do_reset();
    drive(0, 1, 4'b0001, 8'h03); step();
    drive(1, 0, 4'b0001, 8'h00); step();
    drive(0, 0, 4'b0, 8'h00);
    n = 0;
    while (bus.alarm_sound !== 1'b1 && n < 100) begin step(); n++; end
    n_vec++;
    if (bus.alarm_sound !== 1'b1) begin
      n_err++; $display("FAIL reset_ring_enter: got 0 want 1");
    end
    step(); step();
    reset = 1; step();
    n_vec++;
    if (obs() !== 67'd0) begin
      n_err++; $display("FAIL reset_mid_ring: got %h want 0", obs());
    end
    reset = 0;
  endtask

  task automatic test_random();
    int fld;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      fld = $urandom_range(0, 3);
      v = ($urandom_range(0, 1) == 1) ? bcd2($urandom_range(0, field_lim(fld)))
                                      : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 4)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : (4'b0001 << fld), v);
      else
        drive(0, 0, 4'b0, v);
      bus.alarm_ack = ($urandom_range(0, 199) == 0);
      step();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL random_cycle_%0d: got %h want %h", i, obs(), expv());
      end
    end
    drive(0, 0, 4'b0, 8'h00);
    bus.alarm_ack = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    reset = 1;
    bus.alarm_ack = 0;
    drive(0, 0, 4'b0, 8'h00);
    test_reset();
    test_count();
    test_wrap();
    test_bad_writes();
    test_alarm_ack();
    test_ring_timeout();
    test_set_at_tc();
    test_reset_ringing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
